// File: rtl/seq_checker.sv
// Receive-side monitor for the 0/3/2/4/5 cycle generator: predicts each sample
// from the previous one, locks after LOCK_COUNT matches, then flags deviations.
module seq_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       s,
    input  logic             a,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       expected
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       match_q, match_d;
    logic [2:0]       sp_q, sp_d;
    logic             ap_q, ap_d;
    logic [2:0]       exp_q, exp_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             legal;
    logic             err_ev;

    function automatic logic [2:0] nxt(input logic [2:0] v, input logic av);
        case (v)
            3'd0:    return 3'd3;
            3'd3:    return av ? 3'd5 : 3'd2;
            3'd2:    return 3'd4;
            3'd4:    return av ? 3'd3 : 3'd0;
            3'd5:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    always_comb begin
        legal = 1'b0;
        case (s)
            3'd0, 3'd2, 3'd3, 3'd4, 3'd5: legal = 1'b1;
            default:                      legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        sp_d    = sp_q;
        ap_d    = ap_q;
        err_ev  = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (legal) begin
                        sp_d    = s;
                        ap_d    = a;
                        match_d = '0;
                        state_d = SYNC;
                    end else begin
                        err_ev = 1'b1;
                    end
                end
                SYNC: begin
                    if (!legal) begin
                        err_ev  = 1'b1;
                        state_d = HUNT;
                    end else if (s == exp_q) begin
                        sp_d    = s;
                        ap_d    = a;
                        match_d = match_q + 4'd1;
                        if (match_d == 4'(LOCK_COUNT)) state_d = LOCK;
                    end else begin
                        sp_d    = s;
                        ap_d    = a;
                        match_d = '0;
                    end
                end
                LOCK: begin
                    if (!legal) begin
                        err_ev  = 1'b1;
                        state_d = HUNT;
                    end else if (s == exp_q) begin
                        sp_d = s;
                        ap_d = a;
                    end else begin
                        err_ev  = 1'b1;
                        sp_d    = s;
                        ap_d    = a;
                        match_d = '0;
                        state_d = SYNC;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // With en=0 the inputs to nxt() are held, so this reproduces exp_q.
        exp_d = (state_d == HUNT) ? 3'd0 : nxt(sp_d, ap_d);
        err_d = err_ev;

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = err_ev ? CNT_W'(1) : '0;
        end else if (err_ev && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= HUNT;
            match_q <= '0;
            sp_q    <= '0;
            ap_q    <= 1'b0;
            exp_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            sp_q    <= sp_d;
            ap_q    <= ap_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign locked    = (state_q == LOCK);
    assign err       = err_q;
    assign err_count = cnt_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboarded directed + random bench for seq_checker; a second instance with
// CNT_W=2 covers counter saturation and clear/error collision.
module tb_seq_checker;

    localparam int LC = 4;

    logic       clk = 1'b0;
    logic       reset, en, a, clr;
    logic [2:0] s;
    logic       locked, err;
    logic [7:0] err_count;
    logic [2:0] expected;

    logic       reset_b, en_b, clr_b;
    logic [2:0] s_b;
    logic       locked_b, err_b;
    logic [1:0] cnt_b;
    logic [2:0] expected_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_checker #(.LOCK_COUNT(LC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .s(s), .a(a), .clr(clr),
        .locked(locked), .err(err), .err_count(err_count), .expected(expected)
    );

    seq_checker #(.LOCK_COUNT(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .s(s_b), .a(1'b0), .clr(clr_b),
        .locked(locked_b), .err(err_b), .err_count(cnt_b), .expected(expected_b)
    );

    typedef struct packed {
        logic       lk;
        logic       er;
        logic [7:0] cnt;
        logic [2:0] ex;
        logic       b_er;
        logic [1:0] b_cnt;
    } obs_t;

    obs_t sb[$];

    // reference model state: 0=HUNT 1=SYNC 2=LOCK
    int         m_state, m_match;
    logic [2:0] m_sp, m_exp;
    logic       m_ap, m_err;
    logic [7:0] m_cnt;
    logic       bexp_err;
    logic [1:0] bexp_cnt;

    function automatic logic [2:0] ref_nxt(input logic [2:0] v, input logic av);
        case (v)
            3'd0: return 3'd3;
            3'd3: return av ? 3'd5 : 3'd2;
            3'd2: return 3'd4;
            3'd4: return av ? 3'd3 : 3'd0;
            3'd5: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [2:0] sv,
                              input logic av, input logic c);
        logic ev, lg;
        if (!r) begin
            m_state = 0; m_match = 0; m_sp = '0; m_ap = 1'b0;
            m_exp = '0; m_err = 1'b0; m_cnt = '0;
            return;
        end
        ev = 1'b0;
        lg = (sv != 3'd1) && (sv != 3'd6) && (sv != 3'd7);
        if (e) begin
            if (!lg) begin
                ev = 1'b1;
                m_state = 0;
            end else if (m_state == 0) begin
                m_sp = sv; m_ap = av; m_match = 0; m_state = 1;
            end else if (sv == m_exp) begin
                m_sp = sv; m_ap = av;
                if (m_state == 1) begin
                    m_match++;
                    if (m_match == LC) m_state = 2;
                end
            end else begin
                if (m_state == 2) ev = 1'b1;
                m_match = 0; m_sp = sv; m_ap = av; m_state = 1;
            end
            m_exp = (m_state == 0) ? 3'd0 : ref_nxt(m_sp, m_ap);
        end
        m_err = ev;
        if (c) m_cnt = {7'd0, ev};
        else if (ev && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [2:0] sv,
                       input logic av, input logic c);
        obs_t o;
        reset = r; en = e; s = sv; a = av; clr = c;
        model_step(r, e, sv, av, c);
        sb.push_back('{lk: (m_state == 2), er: m_err, cnt: m_cnt, ex: m_exp,
                       b_er: bexp_err, b_cnt: bexp_cnt});
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("locked",    {7'd0, locked},    {7'd0, o.lk});
        check("err",       {7'd0, err},       {7'd0, o.er});
        check("err_count", err_count,         o.cnt);
        check("expected",  {5'd0, expected},  {5'd0, o.ex});
        check("b_err",     {7'd0, err_b},     {7'd0, o.b_er});
        check("b_count",   {6'd0, cnt_b},     {6'd0, o.b_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t1[5];
        logic [2:0] t2[5];
        logic [2:0] rel[4];
        logic [2:0] rs;

        t1  = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd0};
        t2  = '{3'd3, 3'd5, 3'd2, 3'd4, 3'd3};
        rel = '{3'd3, 3'd2, 3'd4, 3'd0};

        reset_b = 1'b0; en_b = 1'b0; s_b = '0; clr_b = 1'b0;
        bexp_err = 1'b0; bexp_cnt = '0;

        // reset, then first lock on stream 0,3,2,4,0
        cyc(0, 1, 3'd7, 0, 0);
        cyc(0, 1, 3'd7, 0, 0);
        check("reset_locked", {7'd0, locked}, 8'd0);
        check("reset_expected", {5'd0, expected}, 8'd0);
        foreach (t1[i]) begin
            cyc(1, 1, t1[i], 0, 0);
            if (i < 4) check("t1_not_locked", {7'd0, locked}, 8'd0);
        end
        check("t1_locked", {7'd0, locked}, 8'd1);
        check("t1_expected", {5'd0, expected}, 8'd3);

        // locked with a=1
        foreach (t2[i]) cyc(1, 1, t2[i], 1, 0);
        check("t2_expected", {5'd0, expected}, 8'd5);

        // steer to expected=4, inject 0, relock
        cyc(1, 1, 3'd5, 1, 0);
        cyc(1, 1, 3'd2, 1, 0);
        check("t3_exp4", {5'd0, expected}, 8'd4);
        cyc(1, 1, 3'd0, 0, 0);
        check("t3_err", {7'd0, err}, 8'd1);
        check("t3_cnt", err_count, 8'd1);
        check("t3_expected", {5'd0, expected}, 8'd3);
        foreach (rel[i]) cyc(1, 1, rel[i], 0, 0);
        check("t3_relock", {7'd0, locked}, 8'd1);

        // illegal codes while locked and in HUNT
        cyc(1, 1, 3'd7, 0, 0);
        cyc(1, 1, 3'd1, 0, 0);
        check("t4_cnt", err_count, 8'd3);
        foreach (t1[i]) cyc(1, 1, t1[i], 0, 0);

        // freeze with garbage, resume
        repeat (3) cyc(1, 0, 3'd6, 0, 0);
        cyc(1, 1, 3'd3, 0, 0);
        check("t6_still_locked", {7'd0, locked}, 8'd1);

        // saturating 2-bit counter on second instance; first instance frozen
        reset_b = 1'b1; en_b = 1'b1; s_b = 3'd7;
        for (int unsigned i = 0; i < 5; i++) begin
            bexp_err = 1'b1;
            bexp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            cyc(1, 0, 3'd6, 0, 0);
        end
        s_b = 3'd0; clr_b = 1'b1; bexp_err = 1'b0; bexp_cnt = 2'd0;
        cyc(1, 0, 3'd6, 0, 0);
        s_b = 3'd7; bexp_err = 1'b1; bexp_cnt = 2'd1;
        cyc(1, 0, 3'd6, 0, 0);
        reset_b = 1'b0; clr_b = 1'b0; bexp_err = 1'b0; bexp_cnt = 2'd0;
        cyc(1, 0, 3'd6, 0, 0);

        // clr while frozen, clr with error, then reset mid-lock
        cyc(1, 0, 3'd6, 0, 1);
        cyc(1, 1, 3'd2, 0, 0);
        cyc(1, 1, 3'd6, 0, 1);
        check("clr_with_err", err_count, 8'd1);
        foreach (t1[i]) cyc(1, 1, t1[i], 0, 0);
        cyc(1, 1, 3'd1, 0, 0);
        foreach (t1[i]) cyc(1, 1, t1[i], 0, 0);
        cyc(0, 1, 3'd3, 0, 0);
        check("rst_locked", {7'd0, locked}, 8'd0);
        check("rst_cnt", err_count, 8'd0);

        // random tail, mostly following the predicted stream
        for (int unsigned k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) rs = 3'($urandom_range(0, 7));
            else if (m_state == 0) rs = 3'd0;
            else rs = m_exp;
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0), rs,
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side monitor for the 5-value cycle generator's output stream (values 0/3/2/4/5 steered by input a).
- Samples the generator's s and a each enabled cycle and predicts the next value from the previous sample.
- Locks after a run of correct predictions and flags and counts every deviation afterwards.
- Sits beside the generator, on its output bus, as the checking end of that interface.

Parameters:
LOCK_COUNT, 4, consecutive correct predictions required to assert locked (legal range 1..15)
CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-low reset
en  input  1  sample enable; when 0 all state holds and err=0
s  input  3  observed generator output
a  input  1  generator steering input, sampled together with s
clr  input  1  synchronous clear of err_count
locked  output  1  1 while in LOCK state
err  output  1  one-cycle pulse on a detected error
err_count  output  CNT_W  saturating error count
expected  output  3  predicted next s; 0 while in HUNT

Behaviour:
- Everything is sampled on rising clk.
- reset==0 at an edge forces the following (reset overrides en and clr):
  - state=HUNT, locked=0, err=0, err_count=0, expected=0, match_cnt=0
  - stored sample (s_p,a_p)=0
- Legal codes are 0,2,3,4,5. Codes 1,6,7 are illegal.
- Next-value function nxt(v,a):
  - 0->3
  - 3->(a?5:2)
  - 2->4
  - 4->(a?3:0)
  - 5->2
- State machine, 2-bit encoded, HUNT/SYNC/LOCK. All actions below happen only when en=1.
- HUNT:
  - Legal s: store (s,a), match_cnt=0, go to SYNC.
  - Illegal s: err=1, err_count+1, stay in HUNT.
- SYNC:
  - s==expected: match_cnt+1, store (s,a). When match_cnt reaches LOCK_COUNT, go to LOCK and set locked=1 on that same edge.
  - s legal but !=expected: no err, match_cnt=0, store (s,a), stay in SYNC.
  - Illegal s: err=1, err_count+1, go to HUNT.
- LOCK:
  - s==expected: store (s,a), stay in LOCK.
  - s legal but !=expected: err=1, err_count+1, locked=0, match_cnt=0, store (s,a), go to SYNC.
  - Illegal s: err=1, err_count+1, locked=0, go to HUNT.
- expected is registered: nxt(stored s, stored a) after any edge that leaves the machine in SYNC or LOCK; 0 in HUNT.
- err:
  - Registered, high for exactly the one cycle after the error edge.
  - Cleared on any edge with no error, including en=0 edges.
- err_count:
  - Saturates at 2^CNT_W-1; no wrap.
  - clr=1 clears it. clr together with an error in the same cycle gives err_count=1, so the event is not lost.
- en=0 freezes state, match_cnt, stored sample, expected, locked and err_count; clr still acts.
- Reset asserted mid-lock drops locked on that edge; no err pulse.
- Latency: first prediction is available 1 edge after the first legal sample. Minimum time to lock is LOCK_COUNT+1 enabled edges after reset release.

Test Plan:
1. reset=0 for 2 edges, then en=1, a=0, s stream 0,3,2,4,0 -> locked=0 through edge 4, locked=1 after edge 5; err never 1; err_count=0; expected=3 after edge 5.
2. Locked with a=1, stream 3,5,2,4,3 -> stays locked; expected sequence 5,2,4,3,5; err=0 throughout.
3. Locked, expected=4, inject s=0 -> err=1 for one cycle, locked=0, err_count=1, state SYNC, expected=3; feed 3,2,4,0 with a=0 -> relock after the 4th match.
4. Illegal s=7 while locked -> err pulse, err_count+1, locked=0, expected=0 (HUNT); next s=1 -> another err pulse, err_count+1, still in HUNT.
5. CNT_W=2: force 5 errors -> err_count 1,2,3,3,3; then clr=1 alone -> 0; clr=1 with an error on the same edge -> 1.
6. Locked, en=0 for 3 edges with garbage s=6 -> no err, all outputs unchanged; en=1 resumes the correct stream with locked=1. Separately, reset=0 while locked -> next edge locked=0, err_count=0, expected=0.
